// File: rtl/matrix_pkg.sv
// Shared types and constants for the 3x3 int8 matrix accelerator and its stream sequencer.
package matrix_pkg;
  localparam int MAT_N  = 3;
  localparam int N_ELEM = 9;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;

  typedef logic signed [DATA_W-1:0] operand_t;
  typedef logic signed [ACC_W-1:0]  result_t;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_t;
endpackage

// File: rtl/matrix_result_buffer.sv
// Result snapshot: all accelerator outputs are captured in one cycle and read back by index.
module matrix_result_buffer #(
  parameter int ACC_W  = 32,
  parameter int N_ELEM = 9,
  parameter int IDX_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [ACC_W*N_ELEM-1:0] mat_c,
  input  logic [IDX_W-1:0]        ridx,
  output logic [ACC_W-1:0]        rdata
);
  logic [ACC_W-1:0] mem [N_ELEM];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ELEM; i++) mem[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < N_ELEM; i++) mem[i] <= mat_c[i*ACC_W +: ACC_W];
    end
  end

  assign rdata = (32'(ridx) < N_ELEM) ? mem[ridx] : '0;
endmodule

// File: rtl/matrix_stream_sequencer.sv
// Byte-stream operand loader, accelerator start/done handshake and result word streamer.
//   state    | meaning
//   ST_LOAD  | accepting 18 operand bytes into mat_a/mat_b
//   ST_RUN   | acc_start high, operands frozen, waiting for acc_done
//   ST_DRAIN | streaming the nine captured results out
module matrix_stream_sequencer #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int N_ELEM = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_last,
  output logic [DATA_W*N_ELEM-1:0] mat_a,
  output logic [DATA_W*N_ELEM-1:0] mat_b,
  output logic                     acc_start,
  input  logic                     acc_done,
  input  logic [ACC_W*N_ELEM-1:0]  mat_c,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [ACC_W-1:0]         res_data,
  output logic                     res_last,
  output logic                     frame_err,
  input  logic                     err_clr,
  output logic                     busy
);
  import matrix_pkg::*;

  localparam logic [4:0] WIDX_LAST = 5'(2*N_ELEM - 1);
  localparam logic [4:0] WIDX_B    = 5'(N_ELEM);
  localparam logic [3:0] RIDX_LAST = 4'(N_ELEM - 1);

  seq_state_t       state, state_nxt;
  logic [4:0]       widx;
  logic [4:0]       bidx;
  logic [3:0]       ridx;
  logic [DATA_W-1:0] opa [N_ELEM];
  logic [DATA_W-1:0] opb [N_ELEM];
  logic             accept_in, accept_out, frame_ok, frame_bad, capture;

  assign in_ready   = (state == ST_LOAD);
  assign acc_start  = (state == ST_RUN);
  assign res_valid  = (state == ST_DRAIN);
  assign res_last   = res_valid && (ridx == RIDX_LAST);

  assign accept_in  = in_valid && in_ready;
  assign accept_out = res_valid && res_ready;
  assign frame_ok   = accept_in && in_last && (widx == WIDX_LAST);
  // Early in_last or a missing in_last on the final byte both abort the frame.
  assign frame_bad  = accept_in && (in_last ^ (widx == WIDX_LAST));
  assign capture    = (state == ST_RUN) && acc_done;
  assign bidx       = widx - WIDX_B;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD:  if (frame_ok) state_nxt = ST_RUN;
      ST_RUN:   if (acc_done) state_nxt = ST_DRAIN;
      ST_DRAIN: if (accept_out && (ridx == RIDX_LAST)) state_nxt = ST_LOAD;
      default:  state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_LOAD;
      busy      <= 1'b0;
      widx      <= '0;
      ridx      <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != ST_LOAD);
      frame_err <= frame_bad || (frame_err && !err_clr);
      if (accept_in) widx <= (frame_ok || frame_bad) ? 5'd0 : widx + 5'd1;
      if (accept_out) ridx <= (ridx == RIDX_LAST) ? 4'd0 : ridx + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ELEM; i++) begin
        opa[i] <= '0;
        opb[i] <= '0;
      end
    end else if (accept_in) begin
      if (widx < WIDX_B) opa[widx[3:0]] <= in_data;
      else               opb[bidx[3:0]] <= in_data;
    end
  end

  always_comb begin
    mat_a = '0;
    mat_b = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      mat_a[i*DATA_W +: DATA_W] = opa[i];
      mat_b[i*DATA_W +: DATA_W] = opb[i];
    end
  end

  matrix_result_buffer #(
    .ACC_W  (ACC_W),
    .N_ELEM (N_ELEM),
    .IDX_W  (4)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (capture),
    .mat_c (mat_c),
    .ridx  (ridx),
    .rdata (res_data)
  );
endmodule

// File: tb/tb_matrix_stream_sequencer.sv
// Directed bench with a behavioural accelerator and a queue of expected result words.
module tb_matrix_stream_sequencer;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_last;
  logic [7:0]   in_data;
  logic [71:0]  mat_a, mat_b;
  logic         acc_start, acc_done;
  logic [287:0] mat_c;
  logic         res_valid, res_ready, res_last;
  logic [31:0]  res_data;
  logic         frame_err, err_clr, busy;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  logic signed [7:0] fb [18];

  always #5 clk = ~clk;

  matrix_stream_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .mat_a(mat_a), .mat_b(mat_b),
    .acc_start(acc_start), .acc_done(acc_done), .mat_c(mat_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_last(res_last), .frame_err(frame_err), .err_clr(err_clr), .busy(busy)
  );

  function automatic logic [287:0] acc_model(input logic [71:0] a, input logic [71:0] b);
    logic [287:0] r;
    int s;
    r = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = 0;
        for (int k = 0; k < 3; k++)
          s += int'($signed(a[(i*3+k)*8 +: 8])) * int'($signed(b[(k*3+j)*8 +: 8]));
        r[(i*3+j)*32 +: 32] = s;
      end
    return r;
  endfunction

  // Accelerator: start -> 3-cycle compute -> one-cycle done -> wait for start low.
  logic [1:0] m_st;
  int         m_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st <= 2'd0; m_cnt <= 0; acc_done <= 1'b0; mat_c <= '0;
    end else begin
      case (m_st)
        2'd0: begin
          acc_done <= 1'b0;
          if (acc_start) begin m_cnt <= 3; m_st <= 2'd1; end
        end
        2'd1: begin
          if (m_cnt == 0) begin
            acc_done <= 1'b1; mat_c <= acc_model(mat_a, mat_b); m_st <= 2'd2;
          end else m_cnt <= m_cnt - 1;
        end
        default: begin
          acc_done <= 1'b0;
          if (!acc_start) m_st <= 2'd0;
        end
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_expect();
    int s;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = 0;
        for (int k = 0; k < 3; k++) s += int'(fb[i*3+k]) * int'(fb[9+k*3+j]);
        exp_q.push_back(s);
      end
  endtask

  // Called at a negedge; sends n bytes, in_last on index last_at.
  task automatic send_frame(input int n, input int last_at, input bit push, input bit clr_on_last);
    int w;
    if (push) push_expect();
    for (int i = 0; i < n; i++) begin
      w = 0;
      while (!in_ready && w < 100) begin @(negedge clk); w++; end
      if (w >= 100) chk("in_ready_wait", 32'(in_ready), 1);
      in_valid = 1'b1;
      in_data  = fb[i];
      in_last  = (i == last_at);
      err_clr  = clr_on_last && (i == n - 1);
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0; err_clr = 1'b0;
  endtask

  task automatic drain(input bit backpressure);
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int n = 0, cyc = 0, vc = 0;
    logic [31:0] e;
    while (n < 9 && cyc < 300) begin
      res_ready = backpressure ? pat[vc % 4] : 1'b1;
      if (res_valid) begin
        e = (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'hDEAD_BEEF;
        chk("res_data", res_data, e);
        chk("res_last", 32'(res_last), 32'(n == 8));
        chk("acc_start_in_drain", 32'(acc_start), 0);
        if (res_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          n++;
        end
        vc++;
      end
      @(negedge clk);
      cyc++;
    end
    if (n < 9) chk("drain_words", n, 9);
    res_ready = 1'b0;
    chk("in_ready_after_drain", 32'(in_ready), 1);
    chk("res_valid_after_drain", 32'(res_valid), 0);
    chk("busy_after_drain", 32'(busy), 0);
  endtask

  task automatic check_started();
    chk("acc_start_rise", 32'(acc_start), 1);
    chk("in_ready_run", 32'(in_ready), 0);
    chk("busy_run", 32'(busy), 1);
    chk("res_valid_run", 32'(res_valid), 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    res_ready = 1'b0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_acc_start", 32'(acc_start), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_last", 32'(res_last), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_mat_zero", 32'(mat_a == '0 && mat_b == '0), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // identity x counting matrix
    for (int i = 0; i < 9; i++) fb[i] = (i % 4 == 0) ? 8'sd1 : 8'sd0;
    for (int i = 0; i < 9; i++) fb[9+i] = 8'(i + 1);
    send_frame(18, 17, 1, 0);
    check_started();
    drain(0);

    // all -128, with result backpressure
    for (int i = 0; i < 18; i++) fb[i] = -8'sd128;
    send_frame(18, 17, 1, 0);
    check_started();
    drain(1);

    // -128 x 127
    for (int i = 9; i < 18; i++) fb[i] = 8'sd127;
    send_frame(18, 17, 1, 0);
    drain(0);

    // early in_last on byte 6
    for (int i = 0; i < 18; i++) fb[i] = 8'($urandom_range(0, 255));
    send_frame(6, 5, 0, 0);
    chk("frame_err_early", 32'(frame_err), 1);
    for (int i = 0; i < 8; i++) begin
      chk("no_start_after_err", 32'(acc_start), 0);
      @(negedge clk);
    end
    send_frame(18, 17, 1, 0);
    check_started();
    drain(0);
    chk("frame_err_sticky", 32'(frame_err), 1);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    chk("frame_err_clr", 32'(frame_err), 0);

    // 18 bytes with no in_last, then set and clear together
    send_frame(18, -1, 0, 0);
    chk("frame_err_no_last", 32'(frame_err), 1);
    chk("no_start_no_last", 32'(acc_start), 0);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    chk("frame_err_clr2", 32'(frame_err), 0);
    send_frame(3, 2, 0, 1);
    chk("frame_err_set_wins", 32'(frame_err), 1);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;

    // reset while running
    for (int i = 0; i < 18; i++) fb[i] = 8'($urandom_range(0, 255));
    send_frame(18, 17, 0, 0);
    chk("acc_start_pre_rst", 32'(acc_start), 1);
    rst_n = 1'b0;
    #1;
    chk("acc_start_async_rst", 32'(acc_start), 0);
    chk("res_valid_async_rst", 32'(res_valid), 0);
    chk("in_ready_async_rst", 32'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("res_valid_after_rst", 32'(res_valid), 0);
      @(negedge clk);
    end
    for (int i = 0; i < 18; i++) fb[i] = 8'($urandom_range(0, 255));
    send_frame(18, 17, 1, 0);
    check_started();
    drain(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/matrix_stream_sequencer.md
# matrix_stream_sequencer

Front-end and back-end sequencer for the 3x3 int8 matrix multiplication accelerator. It accepts a byte stream of 18 signed operands over a valid/ready interface and assembles them into the flattened `mat_a`/`mat_b` operand arrays. It then drives the accelerator's `start`/`done` handshake, snapshots the nine 32-bit results, and streams them out over a valid/ready interface. It sits directly around the accelerator: its operand outputs feed the accelerator, and it consumes the accelerator's `mat_c`/`done`.

## Interface
- `DATA_W`, default 8: operand width, signed.
- `ACC_W`, default 32: result width, signed.
- `N_ELEM`, default 9: elements per matrix. Fixed at 3x3, row-major.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset. Asynchronous assert, active-low.
- `in_valid` in 1: input byte valid.
- `in_ready` out 1: input byte ready.
- `in_data` in DATA_W: operand byte, signed.
- `in_last` in 1: marks the final byte of a frame.
- `mat_a` out DATA_W x N_ELEM: operand A to the accelerator.
- `mat_b` out DATA_W x N_ELEM: operand B to the accelerator.
- `acc_start` out 1: accelerator start.
- `acc_done` in 1: accelerator done.
- `mat_c` in ACC_W x N_ELEM: accelerator result.
- `res_valid` out 1: result word valid.
- `res_ready` in 1: result word ready.
- `res_data` out ACC_W: result word.
- `res_last` out 1: marks the 9th result word.
- `frame_err` out 1: sticky framing error.
- `err_clr` in 1: clears `frame_err`.
- `busy` out 1: high in RUN or DRAIN.

## Operation
- **FSM states:** LOAD, RUN, DRAIN. Reset state is LOAD.
- **LOAD:**
  - `in_ready`=1.
  - A byte is accepted on `in_valid`&`in_ready`.
  - A 5-bit index `widx` (0..17) selects the destination: 0..8 go to `mat_a[widx]`, 9..17 go to `mat_b[widx-9]`.
  - Accepting `widx`=17 with `in_last`=1: go to RUN, reset `widx` to 0.
  - `in_last`=1 at `widx`<17, or `widx`=17 with `in_last`=0: set `frame_err`, discard the frame (`widx`<=0), stay in LOAD. Operand registers may hold partial data; this is harmless because the accelerator is idle.
- **RUN:**
  - `in_ready`=0 and `acc_start`=1.
  - `mat_a`/`mat_b` are frozen.
  - When `acc_done`=1 is sampled: capture all nine `mat_c` words into the result buffer, go to DRAIN, and drop `acc_start` on the next cycle.
- **DRAIN:**
  - `res_valid`=1 and `res_data`=`buf[ridx]`.
  - `res_last`=(`ridx`==8).
  - `ridx` advances on `res_valid`&`res_ready`.
  - Accepting `ridx`=8: go to LOAD, reset `ridx` to 0.
  - Operands stay frozen.
- **Arithmetic and widths:** the result buffer stores `mat_c` unmodified. No arithmetic in this block beyond counters.
- **`frame_err`:** sticky. Cleared by `err_clr`. If set and clear occur in the same cycle, set wins.
- **Accelerator return to idle:** `acc_start` is never re-asserted sooner than 18 accepted bytes after DRAIN exits. This guarantees the accelerator has returned to IDLE (it requires `start` low after done).

## Timing
- **Reset values:**
  - `in_ready`=1 (state LOAD).
  - `acc_start`, `res_valid`, `res_last`, `frame_err`, `busy` = 0.
  - `res_data`, `mat_a`, `mat_b` = 0.
  - `widx`, `ridx` = 0.
- **Reset mid-operation:** all state clears immediately (asynchronous) and `acc_start` falls at once. Any partial frame or undrained results are lost.
- **Start:** `acc_start` rises on the clock edge that accepts byte 17.
- **Drain start:** `res_valid` rises on the edge that samples `acc_done`=1. The first result is visible the same cycle `acc_start` falls.
- **Throughput:** back-to-back full-rate streams sustain one byte per cycle in and one word per cycle out.
- **Output stability:** `res_data` is stable while `res_valid`&!`res_ready`. `mat_a`/`mat_b` change only on accepted LOAD bytes.
- **`acc_done` outside RUN:** ignored.
- **`busy`:** equals (state != LOAD), registered.

## Structure
- **Shared package `matrix_pkg`:**
  - Constants `MAT_N`=3, `N_ELEM`=9, `DATA_W`=8, `ACC_W`=32.
  - Typedefs `operand_t` (signed `DATA_W`) and `result_t` (signed `ACC_W`).
  - Sequencer state enum `seq_state_t`.
- **Sub-module `matrix_result_buffer`:** 9-entry `result_t` capture register with parallel load on `acc_done` and indexed read by `ridx`.
- Top-level FSM, `widx` counter and operand registers stay in `matrix_stream_sequencer`.

## Test plan
- **Identity times counting matrix:** A bytes 1,0,0,0,1,0,0,0,1 followed by B bytes 1..9 (`in_last` on byte 18), with the accelerator model attached.
  - `res_data` sequence 1..9.
  - `res_last` only on the 9th word.
  - Then `in_ready` returns to 1.
- **Signed extremes:** all 18 bytes -128 → every result 49152. All bytes -128 in A and 127 in B → every result -48768.
- **Framing error:** `in_last` on byte 6.
  - `frame_err`=1, `acc_start` never rises.
  - A following valid frame computes correctly with `frame_err` still 1.
  - `err_clr` then gives 0.
- **Result backpressure:** `res_ready` toggles 1,0,0,1… during DRAIN.
  - Each word is held until accepted, no word is dropped or duplicated.
  - `acc_start`=0 throughout DRAIN.
- **Reset mid-RUN:** `rst_n` pulled low for 1 cycle while `acc_start`=1.
  - `acc_start` goes low immediately and `res_valid` stays 0.
  - A fresh frame after reset produces correct results.
